// File: rtl/data_bus_master.sv
// -----------------------------------------------------------------------------
// data_bus_master
// Data-side bus initiator for the MEM stage. Converts a MEM-stage load/store
// into a single SRAM-like transaction (req / addr_ok / data_ok), stalls the
// pipeline while it is outstanding, and holds the last returned load word.
//
// Ports
//   clk, rst             clock, asynchronous active-low reset
//   flush                pipeline flush (exception / eret)
//   stall_all            global stall applied to MEM (includes our own request)
//   mem_read_flag        MEM-stage load
//   mem_write_flag       MEM-stage store
//   mem_sel              byte-lane select
//   mem_addr             byte address
//   mem_write_data       lane-aligned store data
//   stall_request        request to stall the pipeline
//   ram_read_data        captured raw load word, feeds MEM/WB
//   data_req             bus request
//   data_wr              1 = write
//   data_size            0 = byte, 1 = half, 2 = word
//   data_addr            bus address
//   data_wdata           bus write data
//   data_addr_ok         request accepted by the bridge
//   data_data_ok         read data returned / write completed
//   data_rdata           bus read data
// -----------------------------------------------------------------------------
module data_bus_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  stall_all,
  input  logic                  mem_read_flag,
  input  logic                  mem_write_flag,
  input  logic [3:0]            mem_sel,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  stall_request,
  output logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [ADDR_WIDTH-1:0] data_addr,
  output logic [DATA_WIDTH-1:0] data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [DATA_WIDTH-1:0] data_rdata
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_DATA = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_cancel;
  logic                  w_cancel_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wr;
  logic [1:0]            r_size;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic w_access;
  logic w_cancel;
  logic w_latch;
  logic w_capture;
  logic w_stall;
  logic w_req;

  // Lane mask to transfer size; unusual masks fall back to a word access.
  function automatic logic [1:0] sel_to_size(input logic [3:0] sel);
    logic [1:0] size;
    case (sel)
      4'b1111:                            size = 2'd2;
      4'b0011, 4'b1100:                   size = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
      default:                            size = 2'd2;
    endcase
    return size;
  endfunction

  assign w_access = (mem_read_flag | mem_write_flag) & ~flush;
  // A flush in the same cycle as data_ok must discard the data as well.
  assign w_cancel = r_cancel | flush;

  always_comb begin
    w_next        = r_state;
    w_latch       = 1'b0;
    w_capture     = 1'b0;
    w_stall       = 1'b0;
    w_req         = 1'b0;
    w_cancel_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_access;
        if (w_access) begin
          w_latch = 1'b1;
          w_next  = S_REQ;
        end
      end
      S_REQ: begin
        // The request is never withdrawn; a flush only marks it cancelled.
        w_stall       = 1'b1;
        w_req         = 1'b1;
        w_cancel_next = w_cancel;
        if (data_addr_ok) begin
          w_next = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        w_stall       = 1'b1;
        w_cancel_next = w_cancel;
        if (data_data_ok) begin
          w_capture     = ~r_wr & ~w_cancel;
          w_cancel_next = 1'b0;
          w_next        = w_cancel ? S_IDLE : S_DONE;
        end
      end
      S_DONE: begin
        // Wait for the pipeline to move past this instruction so it is
        // not issued a second time.
        if (!stall_all || flush) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cancel <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wr     <= 1'b0;
      r_size   <= 2'd0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_next;
      r_cancel <= w_cancel_next;
      if (w_latch) begin
        r_addr  <= mem_addr;
        r_wdata <= mem_write_data;
        r_wr    <= mem_write_flag;
        r_size  <= sel_to_size(mem_sel);
      end
      if (w_capture) begin
        r_rdata <= data_rdata;
      end
    end
  end

  // stall_request is combinational in IDLE; keep it low while reset is held.
  assign stall_request = w_stall & rst;
  assign data_req      = w_req;
  assign data_wr       = r_wr;
  assign data_size     = r_size;
  assign data_addr     = r_addr;
  assign data_wdata    = r_wdata;
  assign ram_read_data = r_rdata;

endmodule

// File: tb/tb_data_bus_master.sv
module tb_data_bus_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          flush;
  logic          mem_read_flag;
  logic          mem_write_flag;
  logic [3:0]    mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic          stall_request;
  logic [DW-1:0] ram_read_data;
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          tb_extra;
  logic          stall_all;

  assign stall_all = stall_request | tb_extra;

  data_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_all(stall_all),
    .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .stall_request(stall_request), .ram_read_data(ram_read_data),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;
  req_t exp_q[$];

  // Reference model: transaction-level facts about the bus interaction.
  bit            m_req_open;   // request issued, not yet accepted
  bit            m_data_open;  // accepted, response not yet returned
  bit            m_held;       // instruction finished, still held in MEM
  bit            m_cancel;     // outstanding transaction was flushed
  bit            m_wr;
  logic [DW-1:0] m_rd;
  logic          p_stall_all;

  // Bus slave configuration
  int            cfg_adly;
  int            cfg_ddly;
  logic [DW-1:0] cfg_rdata;
  bit            cfg_spur;
  bit            hold_data = 1'b0;
  int            s_phase;
  int            s_cnt;

  function automatic logic [1:0] exp_size(input logic [3:0] sel);
    if (sel == 4'hF) return 2'd2;
    if (sel == 4'h3 || sel == 4'hC) return 2'd1;
    if ($countones(sel) == 1) return 2'd0;
    return 2'd2;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each active edge, using inputs that are stable across it.
  always @(posedge clk) begin : model
    bit   acc;
    req_t r;
    if (!rst) begin
      m_req_open  = 1'b0;
      m_data_open = 1'b0;
      m_held      = 1'b0;
      m_cancel    = 1'b0;
      m_wr        = 1'b0;
      m_rd        = '0;
      exp_q.delete();
    end else begin
      acc = (mem_read_flag | mem_write_flag) & !flush;
      if (m_req_open) begin
        if (flush) m_cancel = 1'b1;
        if (data_addr_ok) begin
          m_req_open  = 1'b0;
          m_data_open = 1'b1;
        end
      end else if (m_data_open) begin
        if (data_data_ok) begin
          if (!m_wr && !(m_cancel || flush)) m_rd = data_rdata;
          m_held      = !(m_cancel || flush);
          m_data_open = 1'b0;
          m_cancel    = 1'b0;
        end else if (flush) begin
          m_cancel = 1'b1;
        end
      end else if (m_held) begin
        if (!p_stall_all || flush) m_held = 1'b0;
      end else if (acc) begin
        m_req_open = 1'b1;
        m_wr       = mem_write_flag;
        r.wr       = mem_write_flag;
        r.size     = exp_size(mem_sel);
        r.addr     = mem_addr;
        r.wdata    = mem_write_data;
        exp_q.push_back(r);
      end
    end
  end

  // Monitor: compares DUT outputs away from the active edge.
  always @(negedge clk) begin : monitor
    bit   acc_now;
    req_t e;
    p_stall_all = stall_all;
    if (mon_en) begin
      acc_now = (mem_read_flag | mem_write_flag) & !flush;
      check("data_req", data_req, m_req_open);
      check("stall_request", stall_request, m_req_open | m_data_open | (!m_held & acc_now));
      check("ram_read_data", ram_read_data, m_rd);
      if (data_req) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL bus_unexpected_req: got data_req=1 expected 0 at %0t", $time);
        end else begin
          e = exp_q[0];
          check("data_wr", data_wr, e.wr);
          check("data_size", data_size, e.size);
          check("data_addr", data_addr, e.addr);
          check("data_wdata", data_wdata, e.wdata);
          if (data_addr_ok) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Bus slave: accepts after cfg_adly cycles, returns data cfg_ddly cycles later.
  initial begin : slave
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    s_phase      = 0;
    s_cnt        = 0;
    forever begin
      @(posedge clk);
      #1;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = $urandom;
      if (!rst) begin
        s_phase = 0;
      end else begin
        if (s_phase == 0) begin
          if (data_req) begin
            s_phase = 1;
            s_cnt   = cfg_adly;
          end else if (cfg_spur) begin
            data_data_ok = ($urandom_range(0, 2) == 0);
          end
        end
        if (s_phase == 1) begin
          if (s_cnt == 0) begin
            data_addr_ok = 1'b1;
            data_data_ok = cfg_spur;
            s_phase      = 2;
            s_cnt        = cfg_ddly;
          end else begin
            s_cnt--;
            data_data_ok = cfg_spur & ($urandom_range(0, 1) == 0);
          end
        end else if (s_phase == 2 && !hold_data) begin
          if (s_cnt == 0) begin
            data_data_ok = 1'b1;
            data_rdata   = cfg_rdata;
            s_phase      = 0;
          end else begin
            s_cnt--;
          end
        end
      end
    end
  end

  // Present one MEM-stage instruction and hold it until the pipeline advances.
  task automatic do_op(input bit rd, input bit wr, input logic [3:0] sel,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input int adly, input int ddly, input logic [DW-1:0] rdat,
                       input bit spur, input int flush_at, input int extra_k,
                       input bit rand_extra);
    int c;
    bit done;
    @(posedge clk);
    #1;
    cfg_adly       = adly;
    cfg_ddly       = ddly;
    cfg_rdata      = rdat;
    cfg_spur       = spur;
    mem_read_flag  = rd;
    mem_write_flag = wr;
    mem_sel        = sel;
    mem_addr       = addr;
    mem_write_data = wd;
    c              = 0;
    flush          = (flush_at == 0);
    tb_extra       = rand_extra ? ($urandom_range(0, 2) == 0) : (c < extra_k);
    done           = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (!stall_all) begin
        done = 1'b1;
      end else if (c > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL retire_timeout: got stall_all=1 after %0d cycles expected release", c);
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        c++;
        flush = (c == flush_at);
        if (flush_at >= 0 && c > flush_at) begin
          mem_read_flag  = 1'b0;
          mem_write_flag = 1'b0;
        end
        tb_extra = rand_extra ? ($urandom_range(0, 2) == 0) : (c < extra_k);
      end
    end
  endtask

  initial begin : driver
    int  guard;
    bit  seen;
    rst            = 1'b0;
    flush          = 1'b0;
    mem_read_flag  = 1'b0;
    mem_write_flag = 1'b0;
    mem_sel        = 4'h0;
    mem_addr       = '0;
    mem_write_data = '0;
    tb_extra       = 1'b0;
    cfg_adly       = 0;
    cfg_ddly       = 0;
    cfg_rdata      = '0;
    cfg_spur       = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall_request", stall_request, 1'b0);
    check("reset_ram_read_data", ram_read_data, '0);
    check("reset_data_req", data_req, 1'b0);
    check("reset_data_wr", data_wr, 1'b0);
    check("reset_data_size", data_size, 2'd0);
    check("reset_data_addr", data_addr, '0);
    check("reset_data_wdata", data_wdata, '0);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;

    // Word load, immediate accept, data one cycle later
    do_op(1, 0, 4'hF, 32'h0000_1004, 32'h0, 0, 0, 32'hDEAD_BEEF, 0, -1, 0, 0);
    check("word_load_data", ram_read_data, 32'hDEAD_BEEF);
    // Byte store with a slow accept; load data must be kept
    do_op(0, 1, 4'b0100, 32'h0000_2002, 32'h00AB_0000, 4, 1, 32'h5555_5555, 0, -1, 0, 0);
    check("store_keeps_data", ram_read_data, 32'hDEAD_BEEF);
    // Load that completes while the pipeline is held by someone else
    do_op(1, 0, 4'hF, 32'h0000_3000, 32'h0, 0, 0, 32'hCAFE_0001, 0, -1, 6, 0);
    check("held_load_data", ram_read_data, 32'hCAFE_0001);
    // Flush during REQ: transaction completes, data discarded
    do_op(1, 0, 4'hF, 32'h0000_4000, 32'h0, 3, 1, 32'h1234_5678, 0, 1, 0, 0);
    check("flushed_load_data", ram_read_data, 32'hCAFE_0001);
    // Back-to-back loads
    do_op(1, 0, 4'hF, 32'h0000_5000, 32'h0, 0, 0, 32'h0000_0001, 0, -1, 0, 0);
    check("b2b_first", ram_read_data, 32'h0000_0001);
    do_op(1, 0, 4'hF, 32'h0000_5004, 32'h0, 0, 0, 32'h0000_0002, 0, -1, 0, 0);
    check("b2b_second", ram_read_data, 32'h0000_0002);

    for (int i = 0; i < 150; i++) begin
      int         typ;
      logic [3:0] sel;
      int         fa;
      typ = $urandom_range(0, 4);
      sel = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      fa  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : -1;
      do_op(typ < 2, (typ == 2) || (typ == 3), sel, $urandom, $urandom,
            $urandom_range(0, 4), $urandom_range(0, 4), $urandom,
            ($urandom_range(0, 3) == 0), fa, 0, 1);
    end

    // Reset while a load waits for its data
    @(posedge clk);
    #1;
    tb_extra       = 1'b0;
    flush          = 1'b0;
    hold_data      = 1'b1;
    cfg_adly       = 0;
    cfg_spur       = 1'b0;
    mem_read_flag  = 1'b1;
    mem_write_flag = 1'b0;
    mem_sel        = 4'hF;
    mem_addr       = 32'h0000_6000;
    guard          = 0;
    seen           = 1'b0;
    while (guard < 50 && !(seen && !data_req)) begin
      @(negedge clk);
      if (data_req) seen = 1'b1;
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_data_timeout: got data_req seen=%0d expected request then accept", seen);
    end
    mon_en = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("rst_stall_request", stall_request, 1'b0);
    check("rst_ram_read_data", ram_read_data, '0);
    check("rst_data_req", data_req, 1'b0);
    check("rst_data_wr", data_wr, 1'b0);
    check("rst_data_size", data_size, 2'd0);
    check("rst_data_addr", data_addr, '0);
    check("rst_data_wdata", data_wdata, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_master.md
Name: data_bus_master

Overview:
- Data-side bus initiator for the MEM stage. Turns the MEM-stage load/store request into an SRAM-like handshake transaction (req/addr_ok/data_ok).
- Stalls the pipeline while a transaction is outstanding.
- Holds the returned load word on ram_read_data, which feeds the MEM/WB register's ram_read_data input.
- Sits between the MEM stage and the data-side cache/AXI bridge.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data bus width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- flush  in  1  pipeline flush (exception/eret)
- stall_all  in  1  global stall currently applied to the MEM stage, including this block's own request
- mem_read_flag  in  1  MEM-stage load
- mem_write_flag  in  1  MEM-stage store
- mem_sel  in  4  byte-lane select
- mem_addr  in  ADDR_WIDTH  byte address
- mem_write_data  in  DATA_WIDTH  store data, already lane-aligned
- stall_request  out  1  request to stall the pipeline
- ram_read_data  out  DATA_WIDTH  captured load word, raw (extension is done in WB)
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  ADDR_WIDTH  bus address
- data_wdata  out  DATA_WIDTH  bus write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  data returned / write done
- data_rdata  in  DATA_WIDTH  bus read data

Behaviour:
- Reset (rst low, async):
  - state = IDLE; cancel = 0.
  - All outputs 0, including ram_read_data, data_req and stall_request.
  - Reset mid-transaction abandons it; the bridge is reset by the same rst.
- Access condition: access = (mem_read_flag | mem_write_flag) & ~flush.
- IDLE:
  - If access: latch addr, wdata, wr = mem_write_flag, and size. Next state is REQ.
  - Size from mem_sel: 1111 → 2; 0011 or 1100 → 1; 0001/0010/0100/1000 → 0; any other value → 2.
  - stall_request = access, combinational in this cycle.
- REQ:
  - data_req = 1 and bus fields = latched values, held stable until data_addr_ok.
  - On data_addr_ok → WAIT_DATA.
  - data_req must drop in the cycle after addr_ok.
- WAIT_DATA:
  - data_req = 0.
  - On data_data_ok:
    - Read and cancel = 0: ram_read_data <= data_rdata.
    - Write: ram_read_data is unchanged.
    - If cancel = 1 → IDLE; otherwise → DONE. Clear cancel.
- DONE:
  - stall_request = 0.
  - If stall_all = 0 (the pipeline advances this edge) → IDLE; else stay in DONE.
  - This guarantees no re-issue of the same instruction.
  - ram_read_data is held until the next read completes.
- stall_request is 1 in REQ and WAIT_DATA, and in IDLE when access is true; it is 0 in DONE.
- Flush while in REQ or WAIT_DATA:
  - The request is never withdrawn (protocol rule); set cancel = 1.
  - The transaction completes, its data is discarded, and the block returns to IDLE.
  - stall_request stays 1 until then, so no new access overlaps.
- Flush while in DONE → IDLE.
- Flush while in IDLE suppresses the issue.
- Only one transaction is ever outstanding.
- data_addr_ok and data_data_ok in the same cycle while in REQ: treat as addr_ok only. The bridge guarantees data_ok comes strictly after addr_ok.
- data_data_ok outside WAIT_DATA is ignored.
- Minimum load latency: the issue cycle (IDLE) → REQ (addr_ok) → WAIT_DATA (data_ok) → DONE. That is 3 stall cycles; ram_read_data is valid from the DONE cycle.

Test Plan:
- Word load, addr 0x0000_1004, sel 1111; addr_ok in the first REQ cycle; data_ok one cycle later with rdata 0xDEAD_BEEF → data_req pulse exactly 1 cycle, size = 2, stall_request high for 3 cycles, ram_read_data = 0xDEAD_BEEF in DONE.
- Byte store, sel 0100, wdata 0x00AB_0000; addr_ok delayed 4 cycles → data_req held 5 cycles with stable addr/wdata, wr = 1, size = 0, ram_read_data unchanged from its prior value.
- Load completes while stall_all = 1 for 3 extra cycles → block stays in DONE, data_req stays 0, no second request; returns to IDLE when stall_all falls.
- flush asserted during REQ of a load, rdata 0x1234_5678 → data_req held until addr_ok, stall_request held until data_ok, ram_read_data unchanged, state IDLE.
- Back-to-back loads returning 0x1 then 0x2 → two distinct transactions, ram_read_data = 0x1 then 0x2; rst pulsed low mid-WAIT_DATA → all outputs 0 immediately.
